// File: rtl/ads7822_pkg.sv
// Shared constants for the ADS7822 serial reader: FSM state codes, slot map,
// sample phase and averaging depth.
package ads7822_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SAMPLE  = 3'd1;
    localparam logic [2:0] NULLBIT = 3'd2;
    localparam logic [2:0] DATA    = 3'd3;
    localparam logic [2:0] GAP     = 3'd4;

    localparam logic [5:0] SAMPLE_SLOTS    = 6'd2;
    localparam logic [5:0] NULL_SLOT       = 6'd2;
    localparam logic [5:0] FIRST_DATA_SLOT = 6'd3;
    localparam logic [5:0] LAST_DATA_SLOT  = 6'd14;

    localparam logic [1:0] PHASE_SAMPLE = 2'd2;

    localparam int AVG_N = 4;
    localparam int ACC_W = 14;

endpackage

// File: rtl/ads7822_reader_dclk_phase_gen.sv
// Phase/slot timebase for the ADS7822 frame; DCLOCK is registered from the
// next phase so it lines up with the slot boundaries seen by the top FSM.
module dclk_phase_gen
    import ads7822_pkg::*;
#(
    parameter int FRAME_SLOTS = 20
) (
    input  logic       clk_X4,
    input  logic       rst_n,
    input  logic       enable,
    output logic [1:0] phase,
    output logic [5:0] slot,
    output logic       dclk
);

    localparam logic [5:0] WRAP_SLOT = 6'(FRAME_SLOTS - 1);

    logic       run;
    logic [1:0] phase_nxt;
    logic [5:0] slot_nxt;

    // The first enabled cycle is slot 0 phase 0; counting starts after it.
    always_comb begin
        phase_nxt = 2'd0;
        slot_nxt  = 6'd0;
        if (run) begin
            phase_nxt = phase + 2'd1;
            slot_nxt  = slot;
            if (phase == 2'd3)
                slot_nxt = (slot == WRAP_SLOT) ? 6'd0 : slot + 6'd1;
        end
    end

    always_ff @(posedge clk_X4) begin
        if (!rst_n || !enable) begin
            run   <= 1'b0;
            phase <= 2'd0;
            slot  <= 6'd0;
            dclk  <= 1'b1;
        end else begin
            run   <= 1'b1;
            phase <= phase_nxt;
            slot  <= slot_nxt;
            dclk  <= (slot_nxt > LAST_DATA_SLOT) | phase_nxt[1];
        end
    end

endmodule

// File: rtl/ads7822_reader.sv
// ADS7822 12-bit serial ADC reader. Define ADS7822_AVG_EN to deliver the
// truncated mean of every AVG_N consecutive frames instead of raw frames.
module ads7822_reader
    import ads7822_pkg::*;
#(
    parameter int FRAME_SLOTS = 20
) (
    input  logic        clk_X4,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        DOUT_6,
    output logic        CS_5,
    output logic        DCLOCK_7,
    output logic [11:0] data,
    output logic        data_valid,
    output logic        null_err
);

    localparam logic [5:0] WRAP_SLOT = 6'(FRAME_SLOTS - 1);

    logic [1:0]  phase;
    logic [5:0]  slot;
    logic [2:0]  state, state_nxt;
    logic [11:0] shreg;
    logic        nbit;
    logic        last_phase, sample_now, frame_end, cs_active_nxt;

    dclk_phase_gen #(.FRAME_SLOTS(FRAME_SLOTS)) u_phase (
        .clk_X4 (clk_X4),
        .rst_n  (rst_n),
        .enable (enable),
        .phase  (phase),
        .slot   (slot),
        .dclk   (DCLOCK_7)
    );

    assign last_phase = (phase == 2'd3);
    assign sample_now = (phase == PHASE_SAMPLE);
    assign frame_end  = enable && (state == DATA) && last_phase && (slot == LAST_DATA_SLOT);

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = SAMPLE;
                SAMPLE:  if (last_phase && slot == SAMPLE_SLOTS - 6'd1) state_nxt = NULLBIT;
                NULLBIT: if (last_phase && slot == NULL_SLOT) state_nxt = DATA;
                DATA:    if (last_phase && slot == LAST_DATA_SLOT) state_nxt = GAP;
                GAP:     if (last_phase && slot == WRAP_SLOT) state_nxt = SAMPLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign cs_active_nxt = (state_nxt == SAMPLE) || (state_nxt == NULLBIT) || (state_nxt == DATA);

`ifdef ADS7822_AVG_EN
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [1:0]       frame_cnt;
    logic             nacc;

    assign sum = acc + {{(ACC_W-12){1'b0}}, shreg};
`endif

    always_ff @(posedge clk_X4) begin
        if (!rst_n) begin
            state      <= IDLE;
            CS_5       <= 1'b1;
            shreg      <= 12'd0;
            nbit       <= 1'b0;
            data       <= 12'd0;
            data_valid <= 1'b0;
            null_err   <= 1'b0;
`ifdef ADS7822_AVG_EN
            acc        <= '0;
            frame_cnt  <= 2'd0;
            nacc       <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            CS_5       <= !cs_active_nxt;
            data_valid <= 1'b0;

            if (state == SAMPLE)
                nbit <= 1'b0;
            if (state == NULLBIT && sample_now && DOUT_6)
                nbit <= 1'b1;
            if (state == DATA && sample_now && slot >= FIRST_DATA_SLOT)
                shreg <= {shreg[10:0], DOUT_6};

`ifdef ADS7822_AVG_EN
            // A dropped enable discards any partially accumulated group.
            if (!enable) begin
                acc       <= '0;
                frame_cnt <= 2'd0;
                nacc      <= 1'b0;
            end else if (frame_end) begin
                if (frame_cnt == 2'(AVG_N - 1)) begin
                    data       <= sum[ACC_W-1:2];
                    data_valid <= 1'b1;
                    null_err   <= nacc | nbit;
                    acc        <= '0;
                    frame_cnt  <= 2'd0;
                    nacc       <= 1'b0;
                end else begin
                    acc       <= sum;
                    frame_cnt <= frame_cnt + 2'd1;
                    nacc      <= nacc | nbit;
                end
            end
`else
            if (frame_end) begin
                data       <= shreg;
                data_valid <= 1'b1;
                null_err   <= nbit;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ads7822_reader.sv
// Randomised bench for ads7822_reader: pin-level ADC model, frame-level reference
// model feeding a scoreboard, and an independent strobe monitor.
module tb_ads7822_reader;

    localparam int FS = 20;

    logic        clk_X4 = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic        DOUT_6 = 1'b0;
    logic        CS_5, DCLOCK_7, data_valid, null_err;
    logic [11:0] data;

    ads7822_reader #(.FRAME_SLOTS(FS)) dut (
        .clk_X4     (clk_X4),
        .rst_n      (rst_n),
        .enable     (enable),
        .DOUT_6     (DOUT_6),
        .CS_5       (CS_5),
        .DCLOCK_7   (DCLOCK_7),
        .data       (data),
        .data_valid (data_valid),
        .null_err   (null_err)
    );

    always #5 clk_X4 = ~clk_X4;

    int cyc = 0;
    always @(posedge clk_X4) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [11:0] w; logic nb; } frame_t;
    typedef struct { logic [11:0] d; logic ne; int at; } exp_t;

    frame_t adc_q[$];
    exp_t   sb[$];
    int     fall_cyc[$];
    frame_t cur;
    int     slot_seen = -1;
    int     low_cnt = 0;
    int     last_fall = 0;
    int     frames_done = 0;
    bit     prev_cs = 1'b1, prev_dck = 1'b1;
    int     acc = 0, acc_n = 0;
    bit     nacc = 1'b0;
    logic [11:0] last_data = 12'd0;

    // ADC pins plus frame-level reference: a frame is complete when CS stayed
    // low for the 15 active slots; its result is due in the cycle CS rises.
    always @(negedge clk_X4) begin
        if (cyc > 1) begin
            if (!rst_n || !enable) begin
                acc = 0; acc_n = 0; nacc = 1'b0;
            end
            if (CS_5 === 1'b0) begin
                if (prev_cs) begin
                    if (adc_q.size() > 0) cur = adc_q.pop_front();
                    else cur = '{w: 12'($urandom), nb: ($urandom_range(0, 7) == 0)};
                    low_cnt = 0;
                    slot_seen = -1;
                    fall_cyc.push_back(cyc);
                end
                low_cnt++;
                if (prev_dck && DCLOCK_7 === 1'b0) begin
                    slot_seen++;
                    if (slot_seen > 0) chk("dclk_period", cyc - last_fall, 4);
                    last_fall = cyc;
                end
            end else begin
                if (!prev_cs && low_cnt == 60) begin
                    chk("dclk_falls_per_frame", slot_seen, 14);
                    frames_done++;
`ifdef ADS7822_AVG_EN
                    acc += int'(cur.w);
                    acc_n++;
                    nacc |= cur.nb;
                    if (acc_n == 4) begin
                        sb.push_back('{d: 12'(acc / 4), ne: nacc, at: cyc});
                        acc = 0; acc_n = 0; nacc = 1'b0;
                    end
`else
                    sb.push_back('{d: cur.w, ne: cur.nb, at: cyc});
`endif
                end
                chk("dclk_high_when_cs_high", DCLOCK_7, 1'b1);
                slot_seen = -1;
            end
            if (slot_seen == 2) DOUT_6 = cur.nb;
            else if (slot_seen >= 3 && slot_seen <= 14) DOUT_6 = cur.w[4'(14 - slot_seen)];
            else DOUT_6 = 1'b0;
            prev_cs  = (CS_5 !== 1'b0);
            prev_dck = (DCLOCK_7 !== 1'b0);
        end
    end

    // Strobe monitor.
    always @(negedge clk_X4) begin
        #1;
        if (data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: data_valid=1 data=0x%0h with nothing expected (cycle %0d)", data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data", data, e.d);
                chk("null_err", null_err, e.ne);
                chk("strobe_cycle", cyc, e.at);
                last_data = e.d;
            end
        end
    end

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames_done < n && t < 200 * 80) begin
            @(posedge clk_X4);
            t++;
        end
        if (frames_done < n) begin
            checks++;
            errors++;
            $display("FAIL wait_frames: got %0d frames expected %0d", frames_done, n);
        end
        @(posedge clk_X4); #2;
    endtask

    task automatic wait_slot(input int s);
        int t = 0;
        do begin
            @(posedge clk_X4); #2;
            t++;
        end while (slot_seen != s && t < 400);
        if (slot_seen != s) begin
            checks++;
            errors++;
            $display("FAIL wait_slot: got %0d expected %0d", slot_seen, s);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cs"}, CS_5, 1'b1);
        chk({tag, "_dclk"}, DCLOCK_7, 1'b1);
        chk({tag, "_data"}, data, 12'd0);
        chk({tag, "_valid"}, data_valid, 1'b0);
        chk({tag, "_null_err"}, null_err, 1'b0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk_X4);
        #1;
        chk_reset_vals("reset");
        #1 rst_n = 1'b1;
        @(posedge clk_X4); #2;

        adc_q.push_back('{w: 12'hA5C, nb: 1'b0});
        adc_q.push_back('{w: 12'hFFF, nb: 1'b0});
        adc_q.push_back('{w: 12'h000, nb: 1'b0});
        adc_q.push_back('{w: 12'hFFF, nb: 1'b0});
        adc_q.push_back('{w: 12'h000, nb: 1'b0});
        adc_q.push_back('{w: 12'h123, nb: 1'b1});
        adc_q.push_back('{w: 12'h3C3, nb: 1'b0});
        enable = 1'b1;
        @(posedge clk_X4); #1;
        chk("cs_fall_latency", CS_5, 1'b0);
        #1;
        wait_frames(7);
        chk("frame_period_1", fall_cyc[1] - fall_cyc[0], 80);
        chk("frame_period_2", fall_cyc[2] - fall_cyc[1], 80);

        // Random frames with random null bits.
        n = frames_done;
        wait_frames(n + 5);

        // Abort mid-frame.
        wait_slot(8);
        enable = 1'b0;
        @(posedge clk_X4); #1;
        chk("abort_cs_high", CS_5, 1'b1);
        chk("abort_dclk_high", DCLOCK_7, 1'b1);
        chk("abort_data_held", data, last_data);
        repeat (20) @(posedge clk_X4);
        #1;
        chk("abort_data_still_held", data, last_data);
        #1;
        adc_q.push_back('{w: 12'h5A5, nb: 1'b0});
        enable = 1'b1;
        @(posedge clk_X4); #1;
        chk("reenable_cs_fall", CS_5, 1'b0);
        #1;
        n = frames_done;
        wait_frames(n + 2);

        // Reset mid-frame with enable still high.
        wait_slot(10);
        rst_n = 1'b0;
        @(posedge clk_X4); #1;
        chk_reset_vals("midreset");
        repeat (3) @(posedge clk_X4);
        #1;
        adc_q.push_back('{w: 12'h100, nb: 1'b0});
        adc_q.push_back('{w: 12'h101, nb: 1'b0});
        adc_q.push_back('{w: 12'h102, nb: 1'b0});
        adc_q.push_back('{w: 12'h103, nb: 1'b0});
        rst_n = 1'b1;
        n = frames_done;
        wait_frames(n + 4);

        n = frames_done;
        wait_frames(n + 4);
        enable = 1'b0;
        repeat (100) @(posedge clk_X4);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ads7822_reader.md
# ads7822_reader

Serial front-end for a TI ADS7822 12-bit sampling ADC, the input-side counterpart of the board's serial DAC driver. It generates CS and DCLOCK from `clk_X4` at one quarter of its rate and shifts in the null bit and D11..D0 from DOUT. Each completed conversion is presented as a parallel 12-bit word with a one-cycle valid strobe. It sits between the ADC pins and the sample consumer, for example a loopback checker feeding the DAC path.

## Interface
- `FRAME_SLOTS`, 20: DCLOCK periods per conversion frame, including the CS-high gap. Legal range 16..63.
- `clk_X4`  in  1  system clock, 4x DCLOCK rate; all logic runs on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  high runs continuous conversions; low aborts and idles.
- `DOUT_6`  in  1  ADC pin 6, serial data.
- `CS_5`  out  1  ADC pin 5, chip select, active-low.
- `DCLOCK_7`  out  1  ADC pin 7, serial clock.
- `data`  out  12  last converted word, held until the next update.
- `data_valid`  out  1  one-cycle strobe when `data` updates.
- `null_err`  out  1  null bit read as 1 in the frame just delivered; updates with `data_valid`.

## Operation
- All outputs are registered. Reset values: `CS_5`=1, `DCLOCK_7`=1, `data`=0, `data_valid`=0, `null_err`=0.
- Slot = 4 `clk_X4` cycles, phases 0..3.
  - Within a slot, `DCLOCK_7` is 0 in phases 0-1 and 1 in phases 2-3.
  - `DOUT_6` is sampled in phase 2, the rising DCLOCK cycle.
- States and slot assignment:
  - IDLE: CS high, DCLOCK high.
  - SAMPLE: slots 0-1, CS low, acquisition clocks, DOUT ignored.
  - NULLBIT: slot 2, DOUT must be 0.
  - DATA: slots 3-14, D11 first, D0 last, shifted MSB-first.
  - GAP: slots 15..`FRAME_SLOTS`-1, CS high, DCLOCK high.
- Transitions:
  - IDLE→SAMPLE on `enable`=1.
  - Each non-IDLE state advances at the end of its last slot.
  - GAP→SAMPLE if `enable`=1, else GAP→IDLE.
- `enable`=0 in any state forces IDLE on the next edge. Any partial word is discarded and no `data_valid` is issued.
- Reset mid-frame behaves the same way and also restores all reset values.
- Capture is a 12-bit shift register, loaded into `data` only at frame end. `data` never shows partial words.
- The null bit is compared only at its phase-2 sample. A 1 sets `null_err` for that frame, and the word is still delivered.

## Timing
- The first CS falling edge is 1 cycle after `enable` rises in IDLE. `CS_5`=0 from the first cycle of slot 0.
- `data_valid`=1 for exactly one cycle, the first cycle of slot 15, with `data` and `null_err` updated in the same cycle.
- Latency from CS low to `data_valid` is 60 cycles. Frame period is 4·`FRAME_SLOTS` cycles, 80 by default.
- Back-to-back frames have no extra gap beyond GAP.
- `enable` falling in the cycle of `data_valid` still lets that strobe complete; the block then goes to IDLE.

## Configuration
- `ADS7822_AVG_EN` defined:
  - A 14-bit accumulator sums 4 consecutive frames.
  - On the 4th frame, `data` = sum[13:2] (truncated) and `data_valid` pulses. On frames 1-3 there is no strobe.
  - `null_err` is the OR over the 4 frames.
  - The accumulator and frame count clear on reset or `enable`=0.
- Undefined: every frame is delivered raw, and no accumulator logic exists.

## Structure
- Package `ads7822_pkg` holds:
  - the state enum (IDLE, SAMPLE, NULLBIT, DATA, GAP);
  - slot constants SAMPLE_SLOTS=2, NULL_SLOT=2, FIRST_DATA_SLOT=3, LAST_DATA_SLOT=14;
  - PHASE_SAMPLE=2;
  - the averaging depth AVG_N=4.
- Sub-module `dclk_phase_gen`: 2-bit phase counter plus slot counter with `FRAME_SLOTS` wrap. It outputs phase, slot and the DCLOCK level, and clears on `rst_n`=0 or `enable`=0.

## Test plan
- ADC model drives 0xA5C with null bit 0, `enable` held high → `data`=0xA5C, `data_valid` pulse 60 cycles after `CS_5` falls, `null_err`=0, next CS fall 80 cycles after the first.
- Alternating frames of 0xFFF and 0x000 → `data` tracks each frame, exactly one strobe per 80 cycles, `DCLOCK_7` period 4 cycles.
- Null bit driven 1 with word 0x123 → `data`=0x123, `null_err`=1. The next clean frame clears `null_err` to 0.
- `enable` dropped at slot 8 → `CS_5`=1 on the next cycle, no `data_valid`, `data` keeps the previous value. Re-enable restarts at slot 0.
- `rst_n`=0 asserted at slot 10 → all outputs at reset values on the next edge. After release with `enable`=1, the first frame yields the correct word.
- With `ADS7822_AVG_EN`, frames 0x100, 0x101, 0x102, 0x103 → a single strobe after the 4th frame with `data`=0x101, and no strobes on frames 1-3.
